// File: rtl/bit_scan_counter_pkg.sv
// Shared types for the bit scan counter: operation select and FSM states.
package bit_scan_pkg;

    typedef enum logic [1:0] {
        MODE_ONES  = 2'b00,
        MODE_ZEROS = 2'b01,
        MODE_TZ    = 2'b10,
        MODE_LZ    = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/bit_scan_counter_chunk_scan.sv
// Combinational statistics on one STEP-bit chunk: popcount, any-one flag,
// and position of the lowest set bit (0 when the chunk is empty).
module chunk_scan #(
    parameter int  STEP = 1,
    localparam int PW   = $clog2(STEP + 1),
    localparam int LW   = (STEP > 1) ? $clog2(STEP) : 1
) (
    input  logic [STEP-1:0] chunk,
    output logic [PW-1:0]   pop,
    output logic            any_one,
    output logic [LW-1:0]   low
);

    // Walk from the top bit down so the last hit recorded is the lowest one.
    always_comb begin
        pop     = '0;
        low     = '0;
        any_one = |chunk;
        for (int i = STEP - 1; i >= 0; i--) begin
            pop = pop + PW'(chunk[i]);
            if (chunk[i]) begin
                low = LW'(i);
            end
        end
    end

endmodule

// File: rtl/bit_scan_counter.sv
// Multi-cycle bit statistics engine: scans a loaded word STEP bits per clock
// and reports ones count, zeros count, trailing zeros or leading zeros.
module bit_scan_counter
    import bit_scan_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  STEP  = 1,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in,
    output logic [CW-1:0]    result,
    output logic             found,
    output logic             busy,
    output logic             done
);

    localparam int NCH = WIDTH / STEP;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = $clog2(STEP + 1);
    localparam int LW  = (STEP > 1) ? $clog2(STEP) : 1;

    state_t           state, state_next;
    mode_t            mode_q;
    logic [WIDTH-1:0] a_reg, a_shift, load_val;
    logic [CW-1:0]    acc, acc_next;
    logic [IW-1:0]    idx;
    logic [PW-1:0]    chunk_pop;
    logic             chunk_any;
    logic [LW-1:0]    chunk_low;
    logic             scan_mode, hit, last_chunk, finish;

    chunk_scan #(.STEP(STEP)) u_chunk (
        .chunk   (a_reg[STEP-1:0]),
        .pop     (chunk_pop),
        .any_one (chunk_any),
        .low     (chunk_low)
    );

    // Word loaded into the shifter; LZ becomes a trailing-zero scan of the reversed word.
    always_comb begin
        load_val = in;
        case (mode)
            MODE_ZEROS: load_val = ~in;
            MODE_LZ: begin
                for (int i = 0; i < WIDTH; i++) begin
                    load_val[i] = in[WIDTH-1-i];
                end
            end
            default: load_val = in;
        endcase
    end

    // Per-chunk accumulator update and scan termination decision.
    always_comb begin
        scan_mode  = (mode_q == MODE_TZ) || (mode_q == MODE_LZ);
        hit        = scan_mode && chunk_any;
        a_shift    = a_reg >> STEP;
        last_chunk = (idx == IW'(NCH - 1));
        acc_next   = acc + CW'(chunk_pop);
        if (scan_mode) begin
            acc_next = acc + (chunk_any ? CW'(chunk_low) : CW'(STEP));
        end
        finish = (a_shift == '0) || hit || last_chunk;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode; DONE waits for start to drop.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = COUNT;
            end
            COUNT: begin
                busy = 1'b1;
                if (finish) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (!start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shifter, accumulator, chunk index and published result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg  <= '0;
            mode_q <= MODE_ONES;
            acc    <= '0;
            idx    <= '0;
            result <= '0;
            found  <= 1'b0;
        end else if (state == IDLE && start) begin
            a_reg  <= load_val;
            mode_q <= mode_t'(mode);
            acc    <= '0;
            idx    <= '0;
        end else if (state == COUNT) begin
            a_reg <= a_shift;
            acc   <= acc_next;
            idx   <= idx + IW'(1);
            if (finish) begin
                if (scan_mode && !hit) begin
                    result <= CW'(WIDTH);
                    found  <= 1'b0;
                end else begin
                    result <= acc_next;
                    found  <= hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_scan_counter.sv
// Self-checking bench for bit_scan_counter: directed table, reset abort, random scans.
module tb_bit_scan_counter;
    import bit_scan_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [1:0]  mode8 = 2'b00, mode16 = 2'b00;
    logic [7:0]  in8 = '0;
    logic [15:0] in16 = '0;
    logic [3:0]  res8;
    logic [4:0]  res16;
    logic        found8, found16, busy8, busy16, done8, done16;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bit_scan_counter #(.WIDTH(8), .STEP(1)) u8 (
        .clk(clk), .reset(reset), .start(start8), .mode(mode8), .in(in8),
        .result(res8), .found(found8), .busy(busy8), .done(done8)
    );

    bit_scan_counter #(.WIDTH(16), .STEP(2)) u16 (
        .clk(clk), .reset(reset), .start(start16), .mode(mode16), .in(in16),
        .result(res16), .found(found16), .busy(busy16), .done(done16)
    );

    typedef struct {
        int          sel;
        mode_t       m;
        logic [15:0] d;
        bit          hold;
        int          res;
        int          fnd;
        int          k;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cur_res(input int sel);
        return (sel != 0) ? int'(res16) : int'(res8);
    endfunction
    function automatic int cur_found(input int sel);
        return (sel != 0) ? int'(found16) : int'(found8);
    endfunction
    function automatic int cur_busy(input int sel);
        return (sel != 0) ? int'(busy16) : int'(busy8);
    endfunction
    function automatic int cur_done(input int sel);
        return (sel != 0) ? int'(done16) : int'(done8);
    endfunction

    // Reference model from the operation definitions: counts and bit positions.
    task automatic model(input int sel, input int m, input logic [15:0] d_in,
                         output int res, output int fnd, output int k);
        int w, s, ones, lo, hi, hi_a;
        logic [15:0] d, a;
        w = (sel != 0) ? 16 : 8;
        s = (sel != 0) ? 2 : 1;
        d = (sel != 0) ? d_in : {8'h00, d_in[7:0]};
        ones = 0; lo = -1; hi = -1;
        for (int i = 0; i < w; i++) begin
            if (d[i]) begin
                ones++;
                hi = i;
                if (lo < 0) lo = i;
            end
        end
        fnd = 0;
        if (m == 0 || m == 1) begin
            res = (m == 0) ? ones : w - ones;
            a = (m == 0) ? d : ~d;
            hi_a = -1;
            for (int i = 0; i < w; i++) if (a[i]) hi_a = i;
            k = (hi_a < 0) ? 1 : hi_a / s + 1;
        end else if (lo < 0) begin
            res = w;
            k = 1;
        end else if (m == 2) begin
            res = lo; fnd = 1; k = lo / s + 1;
        end else begin
            res = w - 1 - hi; fnd = 1; k = (w - 1 - hi) / s + 1;
        end
    endtask

    // One complete handshake; returns published result, found and latency in edges.
    task automatic run_scan(input int sel, input logic [1:0] m, input logic [15:0] d,
                            input bit hold, output int res, output int fnd, output int k);
        bit seen;
        bit excl_ok;
        @(negedge clk);
        if (sel != 0) begin mode16 = m; in16 = d; start16 = 1'b1; end
        else begin mode8 = m; in8 = d[7:0]; start8 = 1'b1; end
        @(posedge clk); #1;
        if (sel != 0) begin
            in16 = 16'($urandom); mode16 = 2'($urandom);
            if (!hold) start16 = 1'b0;
        end else begin
            in8 = 8'($urandom); mode8 = 2'($urandom);
            if (!hold) start8 = 1'b0;
        end
        chk("busy_after_start", cur_busy(sel), 1);
        seen = 1'b0; excl_ok = 1'b1; k = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(posedge clk); #1;
            if (cur_busy(sel) == cur_done(sel)) excl_ok = 1'b0;
            if (cur_done(sel) != 0) begin
                seen = 1'b1;
                k = n;
            end
        end
        chk("busy_done_exclusive", int'(excl_ok), 1);
        res = cur_res(sel);
        fnd = cur_found(sel);
        if (hold) begin
            @(posedge clk); #1;
            chk("done_held", cur_done(sel), 1);
            chk("result_held", cur_res(sel), res);
            @(negedge clk);
            if (sel != 0) start16 = 1'b0; else start8 = 1'b0;
        end
        @(posedge clk); #1;
        chk("done_fall", cur_done(sel), 0);
        chk("idle_busy", cur_busy(sel), 0);
        chk("idle_result_hold", cur_res(sel), res);
    endtask

    vec_t vecs[12];

    initial begin
        int r, f, k, er, ef, ek;
        vecs[0]  = '{0, MODE_ONES,  16'h0001, 1'b1, 1,  0, 1};
        vecs[1]  = '{0, MODE_ONES,  16'h00AA, 1'b1, 4,  0, 8};
        vecs[2]  = '{0, MODE_ZEROS, 16'h00FF, 1'b0, 0,  0, 1};
        vecs[3]  = '{0, MODE_TZ,    16'h0028, 1'b1, 3,  1, 4};
        vecs[4]  = '{0, MODE_LZ,    16'h0028, 1'b0, 2,  1, 3};
        vecs[5]  = '{0, MODE_TZ,    16'h0000, 1'b1, 8,  0, 1};
        vecs[6]  = '{0, MODE_ONES,  16'h0000, 1'b0, 0,  0, 1};
        vecs[7]  = '{0, MODE_ZEROS, 16'h0000, 1'b1, 8,  0, 8};
        vecs[8]  = '{0, MODE_LZ,    16'h0080, 1'b0, 0,  1, 1};
        vecs[9]  = '{1, MODE_ONES,  16'hFFFF, 1'b1, 16, 0, 8};
        vecs[10] = '{1, MODE_TZ,    16'h0100, 1'b0, 8,  1, 5};
        vecs[11] = '{1, MODE_LZ,    16'h0001, 1'b1, 15, 1, 8};

        // Reset state with reset asserted.
        #1;
        chk("rst_result8", int'(res8), 0);
        chk("rst_found8", int'(found8), 0);
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_done8", int'(done8), 0);
        chk("rst_result16", int'(res16), 0);
        chk("rst_done16", int'(done16), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            run_scan(vecs[i].sel, vecs[i].m, vecs[i].d, vecs[i].hold, r, f, k);
            chk($sformatf("vec%0d_result", i), r, vecs[i].res);
            chk($sformatf("vec%0d_found", i), f, vecs[i].fnd);
            chk($sformatf("vec%0d_latency", i), k, vecs[i].k);
        end

        // Reset asserted in the third COUNT cycle of an all-ones scan.
        run_scan(0, MODE_ONES, 16'h00AA, 1'b0, r, f, k);
        @(negedge clk);
        mode8 = MODE_ONES; in8 = 8'hFF; start8 = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_result", int'(res8), 0);
        chk("abort_found", int'(found8), 0);
        chk("abort_busy", int'(busy8), 0);
        chk("abort_done", int'(done8), 0);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_scan(0, MODE_ONES, 16'h000F, 1'b0, r, f, k);
        chk("post_abort_result", r, 4);
        chk("post_abort_found", f, 0);
        chk("post_abort_latency", k, 4);

        // Random scans against the reference model.
        for (int i = 0; i < 40; i++) begin
            int sel;
            logic [1:0] m;
            logic [15:0] d;
            bit hold;
            sel  = int'($urandom_range(0, 1));
            m    = 2'($urandom);
            d    = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d = d & 16'($urandom);
            if ($urandom_range(0, 7) == 0) d = '0;
            hold = 1'($urandom);
            model(sel, int'(m), d, er, ef, ek);
            run_scan(sel, m, d, hold, r, f, k);
            chk($sformatf("rnd%0d_result", i), r, er);
            chk($sformatf("rnd%0d_found", i), f, ef);
            chk($sformatf("rnd%0d_latency", i), k, ek);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
